regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass.sv | 136 +++++++++++++
 tb/tb_regfile_bypass.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// -----------------------------------------------------------------------------
// regfile_bypass
//
// Eight-entry 16-bit register file with two combinational read ports, one
// write-back port, and a per-register pending-write scoreboard that drives a
// read-after-write hazard flag. The hazard consumer owns any stall; this block
// only reports.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write-back value
// to a read port selecting the register being written in the same cycle. The
// hazard term of that port is then dropped when the write retires the last
// outstanding issue to that register.
//
// Ports
//   clk          in   1   clock, all state updates on rising edge
//   rst_n        in   1   synchronous active-low reset
//   read1RegSel  in   3   read port 1 register index
//   read2RegSel  in   3   read port 2 register index
//   read1Data    out  16  read port 1 data (combinational)
//   read2Data    out  16  read port 2 data (combinational)
//   writeRegSel  in   3   write-back destination register
//   writeData    in   16  write-back data
//   writeEn      in   1   commit writeData to writeRegSel
//   issueEn      in   1   a register-writing instruction leaves decode
//   issueRegSel  in   3   destination of the issuing instruction
//   hazard       out  1   a read source has an outstanding write
//   err          out  1   sticky scoreboard overflow/underflow flag
// -----------------------------------------------------------------------------
module regfile_bypass (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  read1RegSel,
  input  logic [2:0]  read2RegSel,
  output logic [15:0] read1Data,
  output logic [15:0] read2Data,
  input  logic [2:0]  writeRegSel,
  input  logic [15:0] writeData,
  input  logic        writeEn,
  input  logic        issueEn,
  input  logic [2:0]  issueRegSel,
  output logic        hazard,
  output logic        err
);

  logic [15:0] r_regs [8];
  logic [1:0]  r_pend [8];
  logic        r_err;

  logic [7:0]  w_inc;
  logic [7:0]  w_dec;
  logic [1:0]  w_pend_nxt [8];
  logic        w_set_err;
  logic        w_haz1;
  logic        w_haz2;

  // One-hot issue / retire strobes per register.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (issueEn) w_inc[issueRegSel] = 1'b1;
    if (writeEn) w_dec[writeRegSel] = 1'b1;
  end

  // Saturating pending counters. Issue and retire on the same register cancel;
  // saturation at either end flags a protocol error instead of wrapping.
  always_comb begin
    w_set_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_pend_nxt[i] = r_pend[i];
      case ({w_inc[i], w_dec[i]})
        2'b10: begin
          if (r_pend[i] == 2'd3) w_set_err = 1'b1;
          else                   w_pend_nxt[i] = r_pend[i] + 2'd1;
        end
        2'b01: begin
          if (r_pend[i] == 2'd0) w_set_err = 1'b1;
          else                   w_pend_nxt[i] = r_pend[i] - 2'd1;
        end
        default: w_pend_nxt[i] = r_pend[i];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  // NOTE: the register array is cleared on reset because software-visible
  // reset contents of 0x0000 are part of the architecture, not just the
  // control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (writeEn) r_regs[writeRegSel] <= writeData;
      for (int i = 0; i < 8; i++) begin
        r_pend[i] <= w_pend_nxt[i];
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // A retiring write that drains the counter to zero fully resolves the
  // hazard for a port it is forwarding to; deeper queues still stall.
  always_comb begin
    w_byp1    = writeEn && (writeRegSel == read1RegSel);
    w_byp2    = writeEn && (writeRegSel == read2RegSel);
    read1Data = w_byp1 ? writeData : r_regs[read1RegSel];
    read2Data = w_byp2 ? writeData : r_regs[read2RegSel];
    w_haz1    = (r_pend[read1RegSel] != 2'd0) &&
                !(w_byp1 && (r_pend[read1RegSel] == 2'd1));
    w_haz2    = (r_pend[read2RegSel] != 2'd0) &&
                !(w_byp2 && (r_pend[read2RegSel] == 2'd1));
  end
`else
  always_comb begin
    read1Data = r_regs[read1RegSel];
    read2Data = r_regs[read2RegSel];
    w_haz1    = (r_pend[read1RegSel] != 2'd0);
    w_haz2    = (r_pend[read2RegSel] != 2'd0);
  end
`endif

  // Both ports on the same register collapse naturally under OR.
  assign hazard = w_haz1 | w_haz2;
  assign err    = r_err;

endmodule

// File: tb/tb_regfile_bypass.sv
// -----------------------------------------------------------------------------
// tb_regfile_bypass
//
// Self-checking bench for regfile_bypass. A table of one-cycle vectors with
// hand-derived expectations covers reset and basic write/read; hand-written
// sequences cover the scoreboard, bypass, simultaneous issue/retire, underflow
// and reset-priority cases with expectations from a small reference model.
// Expectations are queued when stimulus is driven and popped when the
// combinational outputs are sampled, one time unit after the drive.
// Compile with +define+REGFILE_BYPASS_EN to check the bypass build.
// -----------------------------------------------------------------------------
module tb_regfile_bypass;

  logic        clk;
  logic        rst_n;
  logic [2:0]  read1RegSel, read2RegSel;
  logic [15:0] read1Data, read2Data;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic        issueEn;
  logic [2:0]  issueRegSel;
  logic        hazard;
  logic        err;

  regfile_bypass dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .issueEn     (issueEn),
    .issueRegSel (issueRegSel),
    .hazard      (hazard),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [2:0]  r1, r2;
    logic        wen;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic        ien;
    logic [2:0]  isel;
    logic [15:0] e_r1, e_r2;
    logic        e_haz, e_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] r1, r2;
    logic        haz, err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state.
  logic [15:0] m_regs [8];
  int          m_pend [8];
  logic        m_err;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  function automatic bit model_byp(input vec_t v, input logic [2:0] sel);
`ifdef REGFILE_BYPASS_EN
    return v.wen && (v.wsel == sel);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t model_expect(input vec_t v);
    exp_t e;
    bit   h1, h2;
    e.r1  = model_byp(v, v.r1) ? v.wdata : m_regs[v.r1];
    e.r2  = model_byp(v, v.r2) ? v.wdata : m_regs[v.r2];
    h1    = (m_pend[v.r1] != 0) && !(model_byp(v, v.r1) && m_pend[v.r1] == 1);
    h2    = (m_pend[v.r2] != 0) && !(model_byp(v, v.r2) && m_pend[v.r2] == 1);
    e.haz = h1 || h2;
    e.err = m_err;
    return e;
  endfunction

  task automatic model_update(input vec_t v);
    if (!v.rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 16'h0000;
        m_pend[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      if (v.wen) m_regs[v.wsel] = v.wdata;
      if (v.ien && v.wen && v.isel == v.wsel) begin
        // issue and retire cancel
      end else begin
        if (v.ien) begin
          if (m_pend[v.isel] == 3) m_err = 1'b1;
          else m_pend[v.isel]++;
        end
        if (v.wen) begin
          if (m_pend[v.wsel] == 0) m_err = 1'b1;
          else m_pend[v.wsel]--;
        end
      end
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb_q.pop_front();
    check({e.name, ".read1Data"}, read1Data, e.r1);
    check({e.name, ".read2Data"}, read2Data, e.r2);
    check({e.name, ".hazard"},    {15'd0, hazard}, {15'd0, e.haz});
    check({e.name, ".err"},       {15'd0, err},    {15'd0, e.err});
  endtask

  // Drive one cycle of stimulus mid-period, queue its expectation, sample.
  task automatic step(input vec_t v, input bit from_table, input string name);
    exp_t e;
    @(negedge clk);
    rst_n       = v.rst_n;
    read1RegSel = v.r1;
    read2RegSel = v.r2;
    writeEn     = v.wen;
    writeRegSel = v.wsel;
    writeData   = v.wdata;
    issueEn     = v.ien;
    issueRegSel = v.isel;
    if (from_table) begin
      e.r1 = v.e_r1; e.r2 = v.e_r2; e.haz = v.e_haz; e.err = v.e_err;
    end else begin
      e = model_expect(v);
    end
    e.name = name;
    sb_q.push_back(e);
    #1;
    compare_out();
    model_update(v);
  endtask

  function automatic vec_t mk(input logic rst, input logic [2:0] r1, input logic [2:0] r2,
                              input logic wen, input logic [2:0] wsel, input logic [15:0] wdata,
                              input logic ien, input logic [2:0] isel);
    vec_t v;
    v.rst_n = rst; v.r1 = r1; v.r2 = r2;
    v.wen = wen; v.wsel = wsel; v.wdata = wdata;
    v.ien = ien; v.isel = isel;
    v.e_r1 = '0; v.e_r2 = '0; v.e_haz = 1'b0; v.e_err = 1'b0;
    return v;
  endfunction

  function automatic vec_t tv(input logic [2:0] r1, input logic [2:0] r2,
                              input logic wen, input logic [2:0] wsel, input logic [15:0] wdata,
                              input logic ien, input logic [2:0] isel,
                              input logic [15:0] e_r1, input logic [15:0] e_r2,
                              input logic e_haz, input logic e_err);
    vec_t v;
    v = mk(1'b1, r1, r2, wen, wsel, wdata, ien, isel);
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_haz = e_haz; v.e_err = e_err;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    // Vectors after reset: all-zero reads, issue/write/read of R3 and R0.
    tbl[0]  = tv(3'd0, 3'd7, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[1]  = tv(3'd1, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[2]  = tv(3'd3, 3'd4, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[3]  = tv(3'd5, 3'd6, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[4]  = tv(3'd3, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[5]  = tv(3'd2, 3'd4, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[6]  = tv(3'd3, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    tbl[7]  = tv(3'd0, 3'd7, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[8]  = tv(3'd1, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[9]  = tv(3'd1, 3'd2, 1'b1, 3'd0, 16'h00A5, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[10] = tv(3'd0, 3'd3, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h00A5, 16'hBEEF, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0000;
      m_pend[i] = 0;
    end
    m_err = 1'b0;

    rst_n = 1'b0; read1RegSel = '0; read2RegSel = '0;
    writeEn = 1'b0; writeRegSel = '0; writeData = '0;
    issueEn = 1'b0; issueRegSel = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Scoreboard saturation on R2, then drain.
    for (int i = 0; i < 3; i++)
      step(mk(1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2), 1'b0, $sformatf("iss2_%0d", i));
    step(mk(1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2), 1'b0, "iss2_ovf");
    step(mk(1'b1, 3'd0, 3'd2, 1'b1, 3'd2, 16'h0011, 1'b0, 3'd0), 1'b0, "wr2_a");
    step(mk(1'b1, 3'd0, 3'd2, 1'b1, 3'd2, 16'h0022, 1'b0, 3'd0), 1'b0, "wr2_b");
    step(mk(1'b1, 3'd0, 3'd2, 1'b1, 3'd2, 16'h0033, 1'b0, 3'd0), 1'b0, "wr2_c");
    step(mk(1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "rd2_done");

    // Reset with write and issue asserted: reset wins, reads show old data.
    step(mk(1'b0, 3'd3, 3'd2, 1'b1, 3'd3, 16'hFFFF, 1'b1, 3'd3), 1'b0, "rst_prio");
    step(mk(1'b1, 3'd3, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "post_rst");

    // Bypass on R5.
    step(mk(1'b1, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5), 1'b0, "iss5");
    step(mk(1'b1, 3'd0, 3'd5, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0), 1'b0, "byp5");
    step(mk(1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "after5");

    // Simultaneous issue and retire on R6, then on R1/R4.
    step(mk(1'b1, 3'd6, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6), 1'b0, "iss6");
    step(mk(1'b1, 3'd6, 3'd0, 1'b1, 3'd6, 16'h6666, 1'b1, 3'd6), 1'b0, "sim6");
    step(mk(1'b1, 3'd6, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "rd6");
    step(mk(1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4), 1'b0, "iss4");
    step(mk(1'b1, 3'd1, 3'd4, 1'b1, 3'd4, 16'h4444, 1'b1, 3'd1), 1'b0, "iss1_wr4");
    step(mk(1'b1, 3'd1, 3'd4, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "rd1_4");
    step(mk(1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "rd4_4");

    // Underflow on R7, then reset clears it.
    step(mk(1'b1, 3'd7, 3'd7, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0), 1'b0, "unf7");
    step(mk(1'b1, 3'd7, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "rd7");
    step(mk(1'b0, 3'd7, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "rst7");
    step(mk(1'b1, 3'd7, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0), 1'b0, "rd7_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
